// File: rtl/poly_eval_seq_if.sv
// Purpose: handshake/data bundle between a requester and poly_eval_seq.
// Latency: none, wires only.
// Backpressure: none; requester must watch busy, since a start while busy is dropped.
// Ports: start/x/coef flow requester->evaluator; busy/done/result/ovf flow back.
interface poly_eval_seq_if #(
  parameter int WIDTH  = 16,
  parameter int XWIDTH = 3,
  parameter int DEGREE = 2
);
  logic                        start;
  logic [XWIDTH-1:0]           x;
  logic [(DEGREE+1)*WIDTH-1:0] coef;
  logic                        busy;
  logic                        done;
  logic [WIDTH-1:0]            result;
  logic                        ovf;

  modport master (output start, x, coef, input busy, done, result, ovf);
  modport slave  (input start, x, coef, output busy, done, result, ovf);
endinterface

// File: rtl/poly_eval_seq.sv
// Purpose: Horner polynomial evaluator, y = c[N]*x^N + ... + c[0], bit-serial shift-add multiply.
// Latency: done/result/ovf update DEGREE*(XWIDTH+1) cycles after an accepted start, data independent.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, never queued.
// Ports: clk, rst_n (async active-low); io.slave carries start, x, coef in and
//        busy, done (1-cycle pulse), result (held), ovf (held) out.
// Build option: define POLY_SAT_EN to clamp overflowing steps to all-ones instead of wrapping.
module poly_eval_seq #(
  parameter int WIDTH  = 16,
  parameter int XWIDTH = 3,
  parameter int DEGREE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  poly_eval_seq_if.slave   io
);

  localparam int PW = WIDTH + XWIDTH;
  localparam int KW = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
  localparam int BW = (XWIDTH > 1) ? $clog2(XWIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(XWIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc;
  logic [PW-1:0]     prod;
  logic [KW-1:0]     k;
  logic [BW-1:0]     bitc;
  logic [XWIDTH-1:0] x_r;
  logic [WIDTH-1:0]  c_r [DEGREE+1];
  logic              ovf_acc;
  logic              done_r;
  logic [WIDTH-1:0]  result_r;
  logic              ovf_r;

  // One Horner step: low product bits plus the current coefficient, with carry out.
  logic [WIDTH:0]    t;
  logic              step_ovf;
  logic [WIDTH-1:0]  step_val;

  assign t        = {1'b0, prod[WIDTH-1:0]} + {1'b0, c_r[k]};
  assign step_ovf = (|prod[PW-1:WIDTH]) | t[WIDTH];

`ifdef POLY_SAT_EN
  assign step_val = step_ovf ? {WIDTH{1'b1}} : t[WIDTH-1:0];
`else
  assign step_val = t[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = MUL;
      MUL:     if (bitc == BIT_LAST) state_nxt = ADD;
      ADD:     state_nxt = (k == '0) ? IDLE : MUL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      prod     <= '0;
      k        <= '0;
      bitc     <= '0;
      x_r      <= '0;
      ovf_acc  <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      for (int i = 0; i <= DEGREE; i++) c_r[i] <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            for (int i = 0; i <= DEGREE; i++) c_r[i] <= io.coef[i*WIDTH +: WIDTH];
            x_r     <= io.x;
            acc     <= io.coef[DEGREE*WIDTH +: WIDTH];
            k       <= KW'(DEGREE - 1);
            prod    <= '0;
            bitc    <= '0;
            ovf_acc <= 1'b0;
          end
        end
        MUL: begin
          // Always spend XWIDTH cycles so latency never depends on x.
          if (x_r[bitc]) prod <= prod + (PW'(acc) << bitc);
          bitc <= bitc + BW'(1);
        end
        ADD: begin
          acc     <= step_val;
          prod    <= '0;
          bitc    <= '0;
          ovf_acc <= ovf_acc | step_ovf;
          if (k == '0) begin
            result_r <= step_val;
            ovf_r    <= ovf_acc | step_ovf;
            done_r   <= 1'b1;
          end else begin
            k <= k - KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io.busy   = (state != IDLE);
  assign io.done   = done_r;
  assign io.result = result_r;
  assign io.ovf    = ovf_r;

endmodule
